// File: rtl/mem_chk_pkg.sv
// ---------------------------------------------------------------------------
// mem_chk_pkg
// Shared types and constants for the memory pattern checker:
//   state_t      - checker FSM states
//   mode_t       - pattern selector values
//   LFSR_TAPS_*  - Galois (right-shift) feedback masks for DATA_W 8/16/32
//   lfsr_taps()  - picks the feedback mask for a given data width
// ---------------------------------------------------------------------------
package mem_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_ADDR = 2'd0,
        MODE_INV  = 2'd1,
        MODE_WALK = 2'd2,
        MODE_LFSR = 2'd3
    } mode_t;

    // Maximal-length feedback masks for a right-shifting Galois LFSR.
    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    // Only 8, 16 and 32 are supported; any other width falls back to the
    // 32-bit mask truncated by the caller.
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        case (width)
            8:       return {24'd0, LFSR_TAPS_8};
            16:      return {16'd0, LFSR_TAPS_16};
            default: return LFSR_TAPS_32;
        endcase
    endfunction

endpackage

// File: rtl/mem_pattern_gen.sv
// ---------------------------------------------------------------------------
// mem_pattern_gen
// Produces the expected data word P(index) for the current run.
//   clk, rst   - clock / async active-high reset (LFSR register only)
//   mode       - pattern selector (address, inverted address, walking one, LFSR)
//   base       - first word address of the run
//   index      - word index within the run
//   lfsr_load  - reload the LFSR with SEED
//   lfsr_step  - advance the LFSR by one word
//   pattern    - P(index)
// Build option MEM_CHK_LFSR_EN: when defined, mode 3 comes from a DATA_W-bit
// Galois LFSR owned here; when undefined there is no LFSR and mode 3 is the
// same as mode 0.
// ---------------------------------------------------------------------------
module mem_pattern_gen
    import mem_chk_pkg::*;
#(
    parameter int          ADDR_W = 14,
    parameter int          DATA_W = 16,
    parameter int unsigned SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  mode_t             mode,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] index,
    input  logic              lfsr_load,
    input  logic              lfsr_step,
    output logic [DATA_W-1:0] pattern
);

    logic [ADDR_W-1:0]        addr;
    logic [DATA_W+ADDR_W-1:0] addr_wide;
    logic [DATA_W-1:0]        addr_data;
    logic [ADDR_W-1:0]        walk_pos;
    logic [DATA_W-1:0]        walk_data;
    logic [DATA_W-1:0]        mode3_data;

    // Mode 0 data is the wrapped word address, zero-extended or truncated to
    // the data width; the wide concatenation handles either case.
    assign addr      = base + index;
    assign addr_wide = {{DATA_W{1'b0}}, addr};
    assign addr_data = addr_wide[DATA_W-1:0];

    // Walking one follows the run index, not the address.
    assign walk_pos  = index % ADDR_W'(DATA_W);
    assign walk_data = DATA_W'(1) << walk_pos;

`ifdef MEM_CHK_LFSR_EN
    localparam logic [DATA_W-1:0] TAPS   = DATA_W'(lfsr_taps(DATA_W));
    localparam logic [DATA_W-1:0] SEED_V = DATA_W'(SEED);

    logic [DATA_W-1:0] lfsr_q;

    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : '0);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED_V;
        end else if (lfsr_load) begin
            lfsr_q <= SEED_V;
        end else if (lfsr_step) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign mode3_data = lfsr_q;
`else
    logic unused_lfsr_ctl;
    assign unused_lfsr_ctl = ^{clk, rst, lfsr_load, lfsr_step};
    assign mode3_data      = addr_data;
`endif

    always_comb begin
        case (mode)
            MODE_ADDR: pattern = addr_data;
            MODE_INV:  pattern = ~addr_data;
            MODE_WALK: pattern = walk_data;
            default:   pattern = mode3_data;
        endcase
    end

endmodule

// File: rtl/mem_pattern_checker.sv
// ---------------------------------------------------------------------------
// mem_pattern_checker
// Writes a pattern to DEPTH consecutive words starting at base, reads them
// back one at a time and counts mismatches. One memory transaction at most
// is outstanding.
//   clk, rst     - clock / async active-high reset
//   start        - run request (ignored while busy)
//   mode, base   - pattern select and first address, latched at start
//   busy, done   - run in progress / one-cycle end-of-run pulse
//   err          - at least one mismatch in the last run
//   err_count    - saturating mismatch count
//   err_addr     - address of the first mismatch
//   mem_req/we/addr/wdata, mem_ack   - request channel (req held until ack)
//   mem_rvalid/rdata                 - read return channel
// Build option MEM_CHK_LFSR_EN enables the LFSR pattern for mode 3
// (see mem_pattern_gen).
// ---------------------------------------------------------------------------
module mem_pattern_checker
    import mem_chk_pkg::*;
#(
    parameter int          ADDR_W = 14,
    parameter int          DATA_W = 16,
    parameter int          DEPTH  = 256,
    parameter int unsigned SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] err_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    mode_t             mode_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] index_q;
    logic              rd_wait_q;     // read acked, waiting for its data
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] pattern;
    logic              last_word;
    logic              start_accept;
    logic              wr_accept;
    logic              rd_accept;
    logic              mismatch;
    logic              lfsr_load;
    logic              lfsr_step;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign cur_addr     = base_q + index_q;
    assign last_word    = (index_q == LAST_IDX);
    assign start_accept = (state_q == ST_IDLE) && start;
    assign wr_accept    = (state_q == ST_WRITE) && mem_ack;
    // Read data counts only inside the wait window, which opens in the ack
    // cycle itself (zero-latency memories) and stays open until the data.
    assign rd_accept    = (state_q == ST_READ) && mem_rvalid && (rd_wait_q || mem_ack);
    assign mismatch     = rd_accept && (mem_rdata != pattern);

    // Seed reload at run start and again at READ entry so reads replay the
    // write sequence.
    assign lfsr_load = start_accept || (wr_accept && last_word);
    assign lfsr_step = (wr_accept && !last_word) || rd_accept;

    mem_pattern_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SEED   (SEED)
    ) u_gen (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode_q),
        .base      (base_q),
        .index     (index_q),
        .lfsr_load (lfsr_load),
        .lfsr_step (lfsr_step),
        .pattern   (pattern)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)                   state_d = ST_WRITE;
            ST_WRITE: if (mem_ack && last_word)    state_d = ST_READ;
            ST_READ:  if (rd_accept && last_word)  state_d = ST_FIN;
            ST_FIN:                                state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    // Run context, word index and error bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_ADDR;
            base_q    <= '0;
            index_q   <= '0;
            rd_wait_q <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
            err_addr  <= '0;
        end else begin
            if (start_accept) begin
                mode_q    <= mode_t'(mode);
                base_q    <= base;
                index_q   <= '0;
                rd_wait_q <= 1'b0;
                err       <= 1'b0;
                err_count <= '0;
                err_addr  <= '0;
            end
            if (wr_accept) begin
                index_q <= last_word ? '0 : index_q + ADDR_W'(1);
            end
            if ((state_q == ST_READ) && !rd_wait_q && mem_ack && !mem_rvalid) begin
                rd_wait_q <= 1'b1;
            end
            if (rd_accept) begin
                rd_wait_q <= 1'b0;
                index_q   <= index_q + ADDR_W'(1);
            end
            if (mismatch) begin
                err       <= 1'b1;
                err_count <= sat_inc(err_count);
                if (!err) begin
                    err_addr <= cur_addr;
                end
            end
        end
    end

    // Outputs
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_WRITE: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cur_addr;
                mem_wdata = pattern;
            end
            ST_READ: begin
                busy     = 1'b1;
                mem_req  = !rd_wait_q;
                mem_addr = rd_wait_q ? '0 : cur_addr;
            end
            ST_FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_pattern_checker.md
MEM_PATTERN_CHECKER -- requirements
Module: mem_pattern_checker

Interface
REQ-001 SHALL have parameters: ADDR_W, default 14, memory word-address width; DATA_W, default 16, memory data width; DEPTH, default 256, words tested per run (1..2^ADDR_W); SEED, default 16'hACE1, LFSR seed (nonzero).
REQ-002 SHALL have ports:
clk  in  1  sole clock; all logic is rising-edge.
rst  in  1  asynchronous reset, active-high.
start  in  1  single-cycle run request.
mode  in  2  pattern select, sampled at accepted start.
base  in  ADDR_W  first word address, sampled at accepted start.
busy  out  1  run in progress.
done  out  1  one-cycle pulse at run end.
err  out  1  sticky: at least one mismatch in the last run.
err_count  out  16  mismatch count, saturating.
err_addr  out  ADDR_W  address of the first mismatch.
mem_req  out  1  memory request, held until mem_ack.
mem_we  out  1  1 = write, 0 = read.
mem_addr  out  ADDR_W  request address.
mem_wdata  out  DATA_W  write data.
mem_ack  in  1  request accepted this cycle.
mem_rvalid  in  1  read data valid.
mem_rdata  in  DATA_W  read data.

Function
REQ-003 SHALL implement FSM IDLE -> WRITE -> READ -> FIN -> IDLE; at most one outstanding memory transaction.
REQ-004 IDLE: start=1 SHALL latch mode/base, clear err/err_count/err_addr, set index=0, enter WRITE on the next cycle; start while busy SHALL be ignored.
REQ-005 WRITE: SHALL hold mem_req=1, mem_we=1, mem_addr=base+index (mod 2^ADDR_W wrap), mem_wdata=P(index); each mem_ack SHALL increment index; ack at index=DEPTH-1 SHALL reset index=0, reload LFSR seed, enter READ.
REQ-006 READ: SHALL issue mem_req=1, mem_we=0 until mem_ack, then deassert mem_req and wait for mem_rvalid; mem_rvalid SHALL compare mem_rdata against P(index) in the same cycle and then advance index; the last compare SHALL enter FIN.
REQ-007 mem_rvalid outside the wait window SHALL be ignored; mem_rvalid in the same cycle as mem_ack SHALL be accepted.
REQ-008 Mismatch SHALL set err, increment err_count (saturating at 16'hFFFF), and load err_addr only on the first mismatch.
REQ-009 FIN SHALL pulse done for one cycle and return to IDLE; err, err_count and err_addr SHALL hold until the next accepted start.
REQ-010 P(i) by mode: 0 = (base+i) truncated or zero-extended to DATA_W; 1 = bitwise inverse of mode 0; 2 = walking one, 1 << (i mod DATA_W); 3 = LFSR (REQ-015).
REQ-011 busy SHALL be 1 in WRITE, READ and FIN, else 0.
REQ-012 Data-path latency SHALL be zero: a compare completes in the mem_rvalid cycle; minimum run length is 2*DEPTH memory handshakes + 2 cycles.

Reset
REQ-013 rst SHALL force IDLE asynchronously, including mid-run; all outputs SHALL be 0, and index, LFSR and the latched mode/base SHALL clear or reload the seed.
REQ-014 A memory transaction interrupted by reset SHALL be abandoned; no done pulse SHALL be produced.

Configuration
REQ-015 Macro MEM_CHK_LFSR_EN defined: mode 3 uses a DATA_W-bit Galois LFSR, loaded with SEED[DATA_W-1:0] at start and at READ entry, stepping once per accepted word; undefined: no LFSR logic, and mode 3 behaves exactly as mode 0.

Structure
REQ-016 Package mem_chk_pkg SHALL hold the FSM state enum, the mode enum and the LFSR tap constants per supported DATA_W (8, 16, 32).
REQ-017 Sub-module mem_pattern_gen SHALL produce P(index) from mode, base and index, and SHALL own the LFSR register; the FSM stays in the top module.

Verification
REQ-018 Zero-wait model, DEPTH=4, base=0x10, mode 0: writes 0x0010..0x0013, reads match; done pulses once, err=0, err_count=0.
REQ-019 Model corrupts the word at 0x12 (bit 0 flipped): err=1, err_count=1, err_addr=0x12.
REQ-020 Model returns all-zero read data, mode 2, DEPTH=20, DATA_W=16: err_count=20, err_addr=base; a second run with a correct model clears err.
REQ-021 Random ack/rvalid delays of 0-5 cycles, base=2^ADDR_W-2, DEPTH=4: addresses wrap as 3FFE, 3FFF, 0000, 0001; exactly one request is outstanding at any time.
REQ-022 rst asserted during READ, then a new start: no done pulse from the aborted run; the new run completes cleanly; start pulses issued while busy have no effect.
REQ-023 Mode 3, with and without MEM_CHK_LFSR_EN: with the macro, write data equals the LFSR sequence from SEED and the read phase repeats it; without it, data equals mode 0.
